// File: rtl/lab4_branch_scorer_pkg.sv
// rtl/lab4_branch_scorer_pkg.sv - shared state encoding and defaults for the branch trace scorer
package lab4_branch_scorer_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READY   = 3'd1,
        S_PREDICT = 3'd2,
        S_UPDATE  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/lab4_branch_SatCounter.sv
// rtl/lab4_branch_SatCounter.sv - saturating up-counter with synchronous clear
module lab4_branch_SatCounter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    // Clear has priority so a start on the same edge as a final update leaves zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lab4_branch_trace_scorer.sv
// rtl/lab4_branch_trace_scorer.sv - drives a branch predictor from a resolved-branch trace and scores it
// Optional direction counters enabled by defining LAB4_BRANCH_TRACE_SCORER_DIR_EN.
module lab4_branch_trace_scorer
    import lab4_branch_scorer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             trace_val,
    output logic             trace_rdy,
    input  logic [31:0]      trace_pc,
    input  logic             trace_taken,
    input  logic             trace_last,
    output logic [31:0]      bp_pc,
    input  logic             bp_prediction,
    output logic             bp_update_en,
    output logic             bp_update_val,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count,
`ifdef LAB4_BRANCH_TRACE_SCORER_DIR_EN
    output logic [CNT_W-1:0] taken_count,
    output logic [CNT_W-1:0] mispredict_taken_count,
`endif
    output logic             done
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        taken_q, taken_d;
    logic        last_q, last_d;
    logic        pred_q, pred_d;
    logic        accept;
    logic        fire;

    assign trace_rdy = (state_q == S_READY) && !start;
    assign accept    = trace_val && trace_rdy;
    // A start during UPDATE discards the entry, so the strobe and counts are suppressed.
    assign fire      = (state_q == S_UPDATE) && !start;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = taken_q;
        last_d  = last_q;
        pred_d  = pred_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_READY;
            end
            S_READY: begin
                if (start) begin
                    state_d = S_READY;
                end else if (accept) begin
                    state_d = S_PREDICT;
                    pc_d    = trace_pc;
                    taken_d = trace_taken;
                    last_d  = trace_last;
                end
            end
            S_PREDICT: begin
                pred_d  = bp_prediction;
                state_d = start ? S_READY : S_UPDATE;
            end
            S_UPDATE: begin
                if (start)       state_d = S_READY;
                else if (last_q) state_d = S_DONE;
                else             state_d = S_READY;
            end
            S_DONE: begin
                if (start) state_d = S_READY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            taken_q <= 1'b0;
            last_q  <= 1'b0;
            pred_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            last_q  <= last_d;
            pred_q  <= pred_d;
        end
    end

    assign bp_pc         = pc_q;
    assign bp_update_en  = fire;
    assign bp_update_val = taken_q;
    assign mispredict    = fire && (pred_q != taken_q);
    assign done          = (state_q == S_DONE);

    lab4_branch_SatCounter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .inc   (fire),
        .count (branch_count)
    );

    lab4_branch_SatCounter #(.W(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .inc   (mispredict),
        .count (mispredict_count)
    );

`ifdef LAB4_BRANCH_TRACE_SCORER_DIR_EN
    lab4_branch_SatCounter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .inc   (fire && taken_q),
        .count (taken_count)
    );

    lab4_branch_SatCounter #(.W(CNT_W)) u_mispredict_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .inc   (mispredict && taken_q),
        .count (mispredict_taken_count)
    );
`endif

endmodule
